ladybug_input_cond: RTL and testbench
=====================================

LADYBUG_INPUT_COND -- requirements
Module: ladybug_input_cond

Interface
REQ-001 Parameter TICK_DIV, default 20000: clk_sys cycles per internal tick (1 ms at 20 MHz); legal range 2..65535.
REQ-002 Parameter DB_TICKS, default 4: consecutive ticks of disagreement required before a debounced bit changes; legal range 1..15.
REQ-003 Parameter COIN_TICKS, default 50: coin output pulse width, in ticks; legal range 1..255.
REQ-004 Parameter LOCK_TICKS, default 100: dead time after a coin pulse, in ticks; legal range 1..255.
REQ-005 clk_sys  in  1  system clock; the only clock.
REQ-006 res_n  in  1  reset; asynchronous, active-low.
REQ-007 in_raw  in  18  active-high raw controls, asynchronous to clk_sys: [17:16] coin2/coin1, [15:14] fire2/fire, [13:12] bomb2/bomb, [11:10] tilt pair, [9:8] select2/select1, [7:6] up2/up, [5:4] down2/down, [3:2] left2/left, [1:0] right2/right.
REQ-008 out_n  out  18  active-low conditioned controls, same bit map as in_raw, registered.
REQ-009 coin_cnt  out  8  wrapping count of coin pulses issued (both slots), for the LED/debug path.

Function
REQ-010 Each in_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 The prescaler SHALL count 0..TICK_DIV-1 and assert a one-cycle tick when the count equals TICK_DIV-1, then wrap to 0.
REQ-012 Each bit SHALL have a 4-bit debounce counter. On a tick with the synchronized value not equal to the debounced value, the counter increments. Whenever the two values are equal, the counter clears on the next cycle, tick or not.
REQ-013 When a tick arrives with the counter at DB_TICKS-1 and disagreement still present, the debounced bit SHALL take the synchronized value on the next cycle and the counter SHALL clear.
REQ-014 A glitch shorter than DB_TICKS ticks SHALL never change a debounced bit.
REQ-015 Non-coin bits: out_n[i] SHALL equal the inverse of debounced[i].
REQ-016 Each coin slot SHALL have its own FSM with states IDLE, PULSE, LOCKOUT and WAIT_REL, and an 8-bit tick counter.
REQ-017 IDLE: on a debounced rising edge, go to PULSE with counter=0 and drive the coin output low starting the same cycle the FSM enters PULSE.
REQ-018 PULSE: hold the output low and count ticks. On the tick with counter=COIN_TICKS-1, go to LOCKOUT with counter=0, release the output high, and increment coin_cnt once.
REQ-019 LOCKOUT: hold the output high and count ticks. On the tick with counter=LOCK_TICKS-1, go to WAIT_REL.
REQ-020 WAIT_REL: leave for IDLE only when the debounced coin bit is 0. A coin held down SHALL produce exactly one pulse.
REQ-021 Debounced edges arriving in PULSE or LOCKOUT SHALL be ignored and never queued.
REQ-022 If both slots reach PULSE-exit on the same cycle, coin_cnt SHALL increment by 2.
REQ-023 coin_cnt SHALL wrap from 255 to 0.

Reset
REQ-024 On res_n low, asynchronously:
- synchronizers, debounced bits, debounce counters and prescaler go to 0;
- both coin FSMs go to IDLE with counter 0;
- out_n goes to all ones (18'h3FFFF) and coin_cnt to 0.
REQ-025 Reset asserted mid-pulse SHALL release the coin output immediately, and SHALL leave no residual lockout after deassertion.
REQ-026 Coming out of reset with an input already held SHALL give debounce behaviour as a normal 0-to-1 change: for a coin input, one pulse.

Structure
REQ-027 A shared package ladybug_input_pkg SHALL hold:
- the coin FSM state enum;
- bit-index constants for the in_raw/out_n map;
- a constant for the count of coin channels (2).
REQ-028 One sub-module, coin_pulser, SHALL be instantiated twice. Debounce and prescaler logic stay in the top block.

Verification (bench parameters: TICK_DIV=4, DB_TICKS=3, COIN_TICKS=5, LOCK_TICKS=6)
REQ-029 Debounce: raise in_raw[0] and hold it -> out_n[0] falls after the 3rd tick counted from the synchronized edge (within 2+12+1 cycles). A 2-tick pulse on in_raw[0] -> out_n[0] stays 1.
REQ-030 Coin pulse: hold coin1 for 200 cycles -> out_n[16] is low for exactly 20 cycles, only one pulse occurs, and coin_cnt=1.
REQ-031 Re-trigger: in LOCKOUT, release coin1 then press it again -> no pulse. After WAIT_REL and a fresh press -> a second pulse and coin_cnt=2.
REQ-032 Simultaneous: press coin1 and coin2 on the same cycle -> both pulses are aligned and coin_cnt goes 0 to 2 in one cycle.
REQ-033 Reset mid-pulse: drive res_n low during PULSE -> out_n=3FFFF immediately. Release res_n with coin held -> exactly one new pulse.
REQ-034 Wrap: issue 256 coin pulses -> coin_cnt=0.

Source files
------------

// File: rtl/ladybug_input_pkg.sv
// Shared definitions for the Ladybug input conditioner: bit map of the
// raw/conditioned control vectors, coin channel count and coin FSM states.
package ladybug_input_pkg;

  localparam int NUM_IN   = 18;
  localparam int NUM_COIN = 2;

  // Bit positions in in_raw / out_n
  localparam int BIT_RIGHT   = 0;
  localparam int BIT_RIGHT2  = 1;
  localparam int BIT_LEFT    = 2;
  localparam int BIT_LEFT2   = 3;
  localparam int BIT_DOWN    = 4;
  localparam int BIT_DOWN2   = 5;
  localparam int BIT_UP      = 6;
  localparam int BIT_UP2     = 7;
  localparam int BIT_SELECT1 = 8;
  localparam int BIT_SELECT2 = 9;
  localparam int BIT_TILT0   = 10;
  localparam int BIT_TILT1   = 11;
  localparam int BIT_BOMB    = 12;
  localparam int BIT_BOMB2   = 13;
  localparam int BIT_FIRE    = 14;
  localparam int BIT_FIRE2   = 15;
  localparam int BIT_COIN1   = 16;
  localparam int BIT_COIN2   = 17;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    LOCKOUT  = 2'd2,
    WAIT_REL = 2'd3
  } coin_state_e;

endpackage

// File: rtl/ladybug_input_cond_coin_pulser.sv
// One coin slot: turns a debounced coin press into a fixed-width active-low
// pulse, followed by a dead time and a wait for release so a held coin
// yields exactly one pulse.
module coin_pulser
  import ladybug_input_pkg::*;
#(
  parameter int COIN_TICKS = 50,
  parameter int LOCK_TICKS = 100
) (
  input  logic clk_sys,
  input  logic res_n,
  input  logic tick,
  input  logic db_bit,
  input  logic db_rise,
  output logic coin_n,
  output logic done
);

  localparam logic [7:0] COIN_LAST = 8'(COIN_TICKS - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_TICKS - 1);

  coin_state_e state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        coin_n_reg;

  // Next-state logic; done flags the pulse end for the shared coin counter
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (db_rise) state_next = PULSE;
      end
      PULSE: begin
        if (tick) begin
          if (cnt_reg == COIN_LAST) begin
            state_next = LOCKOUT;
            cnt_next   = '0;
            done       = 1'b1;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      LOCKOUT: begin
        if (tick) begin
          if (cnt_reg == LOCK_LAST) begin
            state_next = WAIT_REL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      WAIT_REL: begin
        // A new press landing on the release cycle goes straight to PULSE
        // so it is not lost.
        if (!db_bit) state_next = db_rise ? PULSE : IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, tick counter and output register; output follows the next state
  // so it goes low on the same edge the FSM enters PULSE.
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      coin_n_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      coin_n_reg <= (state_next != PULSE);
    end
  end

  assign coin_n = coin_n_reg;

endmodule

// File: rtl/ladybug_input_cond.sv
// Ladybug control input conditioner: synchronizes and debounces 18 raw
// active-high controls, outputs them active-low, and shapes both coin inputs
// into fixed-width pulses with a wrapping coin counter.
module ladybug_input_cond
  import ladybug_input_pkg::*;
#(
  parameter int TICK_DIV   = 20000,
  parameter int DB_TICKS   = 4,
  parameter int COIN_TICKS = 50,
  parameter int LOCK_TICKS = 100
) (
  input  logic              clk_sys,
  input  logic              res_n,
  input  logic [NUM_IN-1:0] in_raw,
  output logic [NUM_IN-1:0] out_n,
  output logic [7:0]        coin_cnt
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  DB_LAST   = 4'(DB_TICKS - 1);

  logic [NUM_IN-1:0]   sync1_reg, sync2_reg;
  logic [15:0]         presc_reg;
  logic                tick;
  logic [NUM_IN-1:0]   db_reg, db_next;
  logic [3:0]          db_cnt_reg  [NUM_IN];
  logic [3:0]          db_cnt_next [NUM_IN];
  logic [NUM_COIN-1:0] coin_rise, coin_done, coin_n;
  logic [7:0]          coin_cnt_reg, coin_cnt_next;

  // Two-flop synchronizer for the asynchronous raw inputs
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign tick = (presc_reg == TICK_LAST);

  // Prescaler producing a one-cycle tick every TICK_DIV cycles
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) presc_reg <= '0;
    else        presc_reg <= tick ? '0 : presc_reg + 16'd1;
  end

  // Debounce next state: count ticks of disagreement, any agreement clears
  always_comb begin
    db_next = db_reg;
    for (int i = 0; i < NUM_IN; i++) begin
      db_cnt_next[i] = db_cnt_reg[i];
      if (sync2_reg[i] == db_reg[i]) begin
        db_cnt_next[i] = '0;
      end else if (tick) begin
        if (db_cnt_reg[i] == DB_LAST) begin
          db_next[i]     = sync2_reg[i];
          db_cnt_next[i] = '0;
        end else begin
          db_cnt_next[i] = db_cnt_reg[i] + 4'd1;
        end
      end
    end
  end

  // Debounced bits and their counters
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      db_reg <= '0;
      for (int i = 0; i < NUM_IN; i++) db_cnt_reg[i] <= '0;
    end else begin
      db_reg     <= db_next;
      db_cnt_reg <= db_cnt_next;
    end
  end

  // One pulser per coin slot; the rise strobe is taken from the debounce
  // next state so the pulse starts on the edge the debounced bit rises.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COIN; gi++) begin : g_coin
      assign coin_rise[gi] = db_next[BIT_COIN1 + gi] & ~db_reg[BIT_COIN1 + gi];

      coin_pulser #(
        .COIN_TICKS(COIN_TICKS),
        .LOCK_TICKS(LOCK_TICKS)
      ) u_pulser (
        .clk_sys(clk_sys),
        .res_n  (res_n),
        .tick   (tick),
        .db_bit (db_reg[BIT_COIN1 + gi]),
        .db_rise(coin_rise[gi]),
        .coin_n (coin_n[gi]),
        .done   (coin_done[gi])
      );
    end
  endgenerate

  assign out_n = {coin_n, ~db_reg[BIT_COIN1-1:0]};

  // Coin counter increment: one per slot finishing a pulse this cycle
  always_comb begin
    coin_cnt_next = coin_cnt_reg;
    for (int i = 0; i < NUM_COIN; i++) begin
      coin_cnt_next = coin_cnt_next + {7'd0, coin_done[i]};
    end
  end

  // Wrapping coin counter
  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) coin_cnt_reg <= '0;
    else        coin_cnt_reg <= coin_cnt_next;
  end

  assign coin_cnt = coin_cnt_reg;

endmodule

// File: tb/tb_ladybug_input_cond.sv
// Directed bench for ladybug_input_cond: table of static debounce vectors
// plus hand-written coin pulse, re-trigger, simultaneous, reset and wrap runs.
module tb_ladybug_input_cond;
  import ladybug_input_pkg::*;

  localparam int TICK_DIV   = 4;
  localparam int DB_TICKS   = 3;
  localparam int COIN_TICKS = 5;
  localparam int LOCK_TICKS = 6;

  logic        clk_sys = 1'b0;
  logic        res_n   = 1'b0;
  logic [17:0] in_raw  = '0;
  logic [17:0] out_n;
  logic [7:0]  coin_cnt;

  int tests  = 0;
  int errors = 0;

  ladybug_input_cond #(
    .TICK_DIV  (TICK_DIV),
    .DB_TICKS  (DB_TICKS),
    .COIN_TICKS(COIN_TICKS),
    .LOCK_TICKS(LOCK_TICKS)
  ) dut (
    .clk_sys (clk_sys),
    .res_n   (res_n),
    .in_raw  (in_raw),
    .out_n   (out_n),
    .coin_cnt(coin_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Coin output monitor: counts pulses, records width and start cycle
  int   cyc         = 0;
  int   fall_cnt[2] = '{0, 0};
  int   fall_cyc[2] = '{0, 0};
  int   cur_w[2]    = '{0, 0};
  int   last_w[2]   = '{0, 0};
  logic [1:0] prev_n = 2'b11;

  always @(negedge clk_sys) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 2; c++) begin
      if (out_n[BIT_COIN1 + c] == 1'b0) begin
        cur_w[c] <= cur_w[c] + 1;
        if (prev_n[c]) begin
          fall_cnt[c] <= fall_cnt[c] + 1;
          fall_cyc[c] <= cyc;
        end
      end else if (!prev_n[c]) begin
        last_w[c] <= cur_w[c];
        cur_w[c]  <= 0;
      end
      prev_n[c] <= out_n[BIT_COIN1 + c];
    end
  end

  typedef struct {
    logic [17:0] in_v;
    logic [17:0] exp_v;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Wait (bounded) for out_n[bitn] to reach lvl, sampled on falling edges
  task automatic wait_level(input int bitn, input logic lvl, input int bound, input string name);
    bit found = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk_sys);
      if (out_n[bitn] == lvl) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic do_reset();
    in_raw = '0;
    @(negedge clk_sys);
    #2 res_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    res_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base0, base1, k, last_cnt;
    bit   saw_low, rose;

    vecs[0] = '{in_v: 18'h00001, exp_v: 18'h3FFFE};
    vecs[1] = '{in_v: 18'h0FFFF, exp_v: 18'h30000};
    vecs[2] = '{in_v: 18'h0A5A5, exp_v: 18'h35A5A};
    vecs[3] = '{in_v: 18'h05A5A, exp_v: 18'h3A5A5};
    vecs[4] = '{in_v: 18'h08000, exp_v: 18'h37FFF};
    vecs[5] = '{in_v: 18'h00000, exp_v: 18'h3FFFF};

    // Reset state
    repeat (2) @(negedge clk_sys);
    check("reset_out_n", 32'(out_n), 32'h3FFFF);
    check("reset_coin_cnt", 32'(coin_cnt), 32'd0);
    res_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("post_reset_out_n", 32'(out_n), 32'h3FFFF);

    // Static debounce vectors on the non-coin bits
    for (int v = 0; v < 6; v++) begin
      in_raw = vecs[v].in_v;
      repeat (20) @(negedge clk_sys);
      check($sformatf("vec%0d_out_n", v), 32'(out_n), 32'(vecs[v].exp_v));
    end
    check("vec_coin_cnt", 32'(coin_cnt), 32'd0);

    // Debounce latency on bit 0: 11..15 cycles after the raw change
    k = 0;
    in_raw[0] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_sys);
      if (out_n[0] == 1'b0) begin
        k = n;
        break;
      end
    end
    check($sformatf("db_latency_%0d_in_11_15", k), 32'(k >= 11 && k <= 15), 32'd1);
    in_raw[0] = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("db_release", 32'(out_n[0]), 32'd1);

    // Two-tick glitch must never reach the output
    saw_low = 1'b0;
    in_raw[0] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_sys);
      if (n == 7) in_raw[0] = 1'b0;
      if (!out_n[0]) saw_low = 1'b1;
    end
    check("glitch_ignored", 32'(saw_low), 32'd0);

    // Held coin: one 20-cycle pulse
    base0 = fall_cnt[0];
    base1 = fall_cnt[1];
    in_raw[BIT_COIN1] = 1'b1;
    wait_level(BIT_COIN1, 1'b0, 20, "coin1_start");
    repeat (190) @(negedge clk_sys);
    in_raw[BIT_COIN1] = 1'b0;
    repeat (40) @(negedge clk_sys);
    check("held_pulse_count", 32'(fall_cnt[0] - base0), 32'd1);
    check("held_pulse_width", 32'(last_w[0]), 32'd20);
    check("held_coin_cnt", 32'(coin_cnt), 32'd1);
    check("held_coin2_quiet", 32'(fall_cnt[1] - base1), 32'd0);

    // Re-trigger during lockout is ignored; a fresh press after release pulses
    do_reset();
    check("retrig_reset_cnt", 32'(coin_cnt), 32'd0);
    base0 = fall_cnt[0];
    in_raw[BIT_COIN1] = 1'b1;
    wait_level(BIT_COIN1, 1'b0, 20, "retrig_first_start");
    repeat (6) @(negedge clk_sys);
    in_raw[BIT_COIN1] = 1'b0;
    repeat (16) @(negedge clk_sys);
    in_raw[BIT_COIN1] = 1'b1;
    repeat (100) @(negedge clk_sys);
    check("retrig_no_second_pulse", 32'(fall_cnt[0] - base0), 32'd1);
    check("retrig_cnt_one", 32'(coin_cnt), 32'd1);
    in_raw[BIT_COIN1] = 1'b0;
    repeat (20) @(negedge clk_sys);
    in_raw[BIT_COIN1] = 1'b1;
    wait_level(BIT_COIN1, 1'b0, 20, "retrig_fresh_start");
    wait_level(BIT_COIN1, 1'b1, 25, "retrig_fresh_end");
    repeat (2) @(negedge clk_sys);
    check("retrig_fresh_width", 32'(last_w[0]), 32'd20);
    check("retrig_cnt_two", 32'(coin_cnt), 32'd2);
    in_raw[BIT_COIN1] = 1'b0;
    repeat (60) @(negedge clk_sys);

    // Simultaneous presses: aligned pulses, count jumps 0 -> 2 in one cycle
    do_reset();
    in_raw[BIT_COIN2:BIT_COIN1] = 2'b11;
    wait_level(BIT_COIN1, 1'b0, 20, "simul_start");
    check("simul_coin2_aligned", 32'(out_n[BIT_COIN2]), 32'd0);
    last_cnt = coin_cnt;
    rose = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_sys);
      if (out_n[BIT_COIN1]) begin
        rose = 1'b1;
        break;
      end
      last_cnt = coin_cnt;
    end
    check("simul_end_seen", 32'(rose), 32'd1);
    check("simul_cnt_before", 32'(last_cnt), 32'd0);
    check("simul_cnt_after", 32'(coin_cnt), 32'd2);
    check("simul_coin2_end", 32'(out_n[BIT_COIN2]), 32'd1);
    in_raw[BIT_COIN2:BIT_COIN1] = 2'b00;
    repeat (60) @(negedge clk_sys);
    check("simul_same_start_cycle", 32'(fall_cyc[0] == fall_cyc[1]), 32'd1);

    // Reset in the middle of a pulse, then release with the coin held
    in_raw[BIT_COIN1] = 1'b1;
    wait_level(BIT_COIN1, 1'b0, 20, "rstmid_start");
    repeat (5) @(negedge clk_sys);
    #2 res_n = 1'b0;
    #1;
    check("rstmid_out_n", 32'(out_n), 32'h3FFFF);
    check("rstmid_coin_cnt", 32'(coin_cnt), 32'd0);
    repeat (3) @(negedge clk_sys);
    res_n = 1'b1;
    @(negedge clk_sys);
    base0 = fall_cnt[0];
    wait_level(BIT_COIN1, 1'b0, 25, "rstmid_new_start");
    wait_level(BIT_COIN1, 1'b1, 25, "rstmid_new_end");
    repeat (100) @(negedge clk_sys);
    check("rstmid_one_pulse", 32'(fall_cnt[0] - base0), 32'd1);
    check("rstmid_width", 32'(last_w[0]), 32'd20);
    check("rstmid_cnt", 32'(coin_cnt), 32'd1);
    in_raw[BIT_COIN1] = 1'b0;
    repeat (30) @(negedge clk_sys);

    // Wrap: 128 dual presses = 256 pulses
    do_reset();
    base0 = fall_cnt[0];
    base1 = fall_cnt[1];
    for (int i = 0; i < 128; i++) begin
      in_raw[BIT_COIN2:BIT_COIN1] = 2'b11;
      wait_level(BIT_COIN1, 1'b0, 20, $sformatf("wrap_start_%0d", i));
      in_raw[BIT_COIN2:BIT_COIN1] = 2'b00;
      repeat (55) @(negedge clk_sys);
      if (i == 126) check("wrap_cnt_254", 32'(coin_cnt), 32'd254);
    end
    check("wrap_pulses_coin1", 32'(fall_cnt[0] - base0), 32'd128);
    check("wrap_pulses_coin2", 32'(fall_cnt[1] - base1), 32'd128);
    check("wrap_cnt_zero", 32'(coin_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
